// File: rtl/sccb_init_seq.sv
// Table-driven SCCB configuration sequencer: walks a ROM register table on `go`,
// issues one SCCB write per entry, inserts ms delays, retries failed writes.
module sccb_init_seq #(
    parameter logic [7:0] DEV_ID     = 8'h42,
    parameter int         ADDR_W     = 8,
    parameter int         DELAY_UNIT = 25000,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 4096
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              go,
    output logic              busy,
    output logic              seq_done,
    output logic              err,
    output logic [ADDR_W-1:0] err_idx,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_ip_addr,
    output logic [7:0]        sccb_sub_addr,
    output logic [7:0]        sccb_wdata,
    output logic              sccb_rw,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic [2:0]        dbg_state
);

    // Handshake: sccb_start is a one-cycle request; the core answers with a one-cycle
    // sccb_done, and sccb_nack is meaningful only in that cycle. done outside WAIT is dropped.

    localparam int DLY_W = $clog2(254 * DELAY_UNIT + 1);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [RT_W-1:0]   retry_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [DLY_W-1:0]  dly_cnt;

    logic is_end, is_dly, last_idx, can_retry, wait_ok, wait_fail;

    assign is_end    = (rom_data == 16'hFFFF);
    assign is_dly    = (rom_data[15:8] == 8'hFF) && !is_end;
    assign last_idx  = (idx == {ADDR_W{1'b1}});
    assign can_retry = (retry_cnt < RT_W'(MAX_RETRY));
    // A done pulse always beats a coincident timeout expiry.
    assign wait_ok   = (state == S_WAIT) && sccb_done && !sccb_nack;
    assign wait_fail = (state == S_WAIT) &&
                       ((sccb_done && sccb_nack) || (!sccb_done && (to_cnt == TO_W'(TIMEOUT - 1))));

    assign busy         = (state != S_IDLE);
    assign seq_done     = (state == S_FINISH);
    assign sccb_start   = (state == S_ISSUE);
    assign sccb_ip_addr = DEV_ID;
    assign sccb_rw      = 1'b0;
    assign rom_addr     = idx;
    assign dbg_state    = state;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (go) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_end)      state_nxt = S_FINISH;
                else if (is_dly) state_nxt = (rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
                else             state_nxt = S_ISSUE;
            end
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_ok)        state_nxt = S_NEXT;
                else if (wait_fail) state_nxt = can_retry ? S_ISSUE : S_FINISH;
            end
            S_DELAY:  if (dly_cnt == DLY_W'(1)) state_nxt = S_NEXT;
            S_NEXT:   state_nxt = last_idx ? S_FINISH : S_FETCH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            idx           <= '0;
            retry_cnt     <= '0;
            to_cnt        <= '0;
            dly_cnt       <= '0;
            err           <= 1'b0;
            err_idx       <= '0;
            sccb_sub_addr <= 8'd0;
            sccb_wdata    <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        idx       <= '0;
                        retry_cnt <= '0;
                        err       <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (is_dly) begin
                        dly_cnt <= DLY_W'(rom_data[7:0]) * DLY_W'(DELAY_UNIT);
                    end else if (!is_end) begin
                        sccb_sub_addr <= rom_data[15:8];
                        sccb_wdata    <= rom_data[7:0];
                    end
                end
                S_ISSUE: to_cnt <= '0;
                S_WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (wait_fail) begin
                        if (can_retry) begin
                            retry_cnt <= retry_cnt + RT_W'(1);
                        end else begin
                            err     <= 1'b1;
                            err_idx <= idx;
                        end
                    end
                end
                S_DELAY: dly_cnt <= dly_cnt - DLY_W'(1);
                S_NEXT: begin
                    retry_cnt <= '0;
                    // The table never wraps: the last index finishes the sequence.
                    if (!last_idx) idx <= idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq with a synchronous ROM model and a
// behavioural SCCB core that can ack late, NACK selectively or stay silent.
module tb_sccb_init_seq;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        go = 1'b0;
    logic        busy, seq_done, err, sccb_start, sccb_rw;
    logic [2:0]  err_idx, rom_addr, dbg_state;
    logic [15:0] rom_data = 16'hFFFF;
    logic [7:0]  sccb_ip_addr, sccb_sub_addr, sccb_wdata;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;

    sccb_init_seq #(
        .DEV_ID(8'h42), .ADDR_W(3), .DELAY_UNIT(5), .MAX_RETRY(3), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .go(go), .busy(busy), .seq_done(seq_done),
        .err(err), .err_idx(err_idx), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_start(sccb_start), .sccb_ip_addr(sccb_ip_addr), .sccb_sub_addr(sccb_sub_addr),
        .sccb_wdata(sccb_wdata), .sccb_rw(sccb_rw), .sccb_done(sccb_done),
        .sccb_nack(sccb_nack), .dbg_state(dbg_state)
    );

    always #5 PCLK = ~PCLK;

    // Synchronous ROM: data appears the cycle after the address.
    logic [15:0] rom [0:7];
    always @(posedge PCLK) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge PCLK) cyc++;

    int n_chk = 0;
    int n_pass = 0;
    int g_cyc;

    logic [15:0] st_log[$];
    int          st_cyc[$];
    int          dn_cyc[$];
    int          sd_cnt, sd_cyc;

    int         core_lat = 10;
    bit         core_silent = 0;
    logic [7:0] nack_sub = 8'h00;
    int         nack_n = 0;
    bit         pend = 0, pend_nack = 0;
    int         pend_cnt = 0;

    // Core model and monitor, both on the inactive edge.
    always @(negedge PCLK) begin
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        if (!PRESETN) pend = 0;
        else if (pend) begin
            if (pend_cnt == 0) begin
                sccb_done = 1'b1;
                sccb_nack = pend_nack;
                pend = 0;
                dn_cyc.push_back(cyc);
            end else pend_cnt--;
        end
        if (sccb_start) begin
            st_log.push_back({sccb_sub_addr, sccb_wdata});
            st_cyc.push_back(cyc);
            if (!core_silent) begin
                pend = 1;
                pend_cnt = core_lat - 1;
                pend_nack = (sccb_sub_addr == nack_sub) && (nack_n > 0);
                if (pend_nack) nack_n--;
            end
        end
        if (seq_done) begin
            sd_cnt++;
            sd_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    endtask

    task automatic start_seq();
        st_log.delete(); st_cyc.delete(); dn_cyc.delete();
        sd_cnt = 0;
        tick();
        go = 1'b1;
        g_cyc = cyc;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_seq(input int budget);
        int n = 0;
        while (sd_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (sd_cnt == 0) begin
            n_chk++;
            $display("FAIL seq_done_wait: none within %0d cycles", budget);
        end
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (seq_done !== 1'b0) $display("FAIL rst_seq_done: got %b want 0", seq_done); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        n_chk++; if (sccb_start !== 1'b0) $display("FAIL rst_start: got %b want 0", sccb_start); else n_pass++;
        n_chk++; if (sccb_rw !== 1'b0) $display("FAIL rst_rw: got %b want 0", sccb_rw); else n_pass++;
        n_chk++; if (err_idx !== 3'd0) $display("FAIL rst_err_idx: got %0d want 0", err_idx); else n_pass++;
        n_chk++; if (rom_addr !== 3'd0) $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); else n_pass++;
        n_chk++; if (sccb_sub_addr !== 8'h00) $display("FAIL rst_sub: got %h want 00", sccb_sub_addr); else n_pass++;
        n_chk++; if (sccb_wdata !== 8'h00) $display("FAIL rst_wdata: got %h want 00", sccb_wdata); else n_pass++;
        n_chk++; if (sccb_ip_addr !== 8'h42) $display("FAIL rst_ip_addr: got %h want 42", sccb_ip_addr); else n_pass++;
        n_chk++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else n_pass++;
        PRESETN = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        core_lat = 10; core_silent = 0; nack_n = 0;
        start_seq();
        wait_seq(400);
        n_chk++; if (st_log.size() !== 2) $display("FAIL basic_starts: got %0d want 2", st_log.size()); else n_pass++;
        n_chk++; if (st_log[0] !== 16'h1280) $display("FAIL basic_w0: got %h want 1280", st_log[0]); else n_pass++;
        n_chk++; if (st_log[1] !== 16'h1101) $display("FAIL basic_w1: got %h want 1101", st_log[1]); else n_pass++;
        n_chk++; if (st_cyc[0] !== g_cyc + 3) $display("FAIL basic_first_lat: got %0d want %0d", st_cyc[0], g_cyc + 3); else n_pass++;
        n_chk++; if (st_cyc[1] !== dn_cyc[0] + 4) $display("FAIL basic_next_lat: got %0d want %0d", st_cyc[1], dn_cyc[0] + 4); else n_pass++;
        n_chk++; if (sd_cyc !== dn_cyc[1] + 4) $display("FAIL basic_done_lat: got %0d want %0d", sd_cyc, dn_cyc[1] + 4); else n_pass++;
        n_chk++; if (sd_cnt !== 1) $display("FAIL basic_sd_cnt: got %0d want 1", sd_cnt); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_delay();
        // done edge D: NEXT, FETCH, DECODE, 2*5 DELAY cycles, NEXT, FETCH, DECODE, then ISSUE.
        load_rom(16'h1280, 16'hFF02, 16'h1101, 16'hFFFF);
        core_lat = 10;
        start_seq();
        wait_seq(400);
        n_chk++; if (st_log.size() !== 2) $display("FAIL dly_starts: got %0d want 2", st_log.size()); else n_pass++;
        n_chk++; if (st_log[1] !== 16'h1101) $display("FAIL dly_w1: got %h want 1101", st_log[1]); else n_pass++;
        n_chk++; if (st_cyc[1] - dn_cyc[0] !== 17) $display("FAIL dly_gap: got %0d want 17", st_cyc[1] - dn_cyc[0]); else n_pass++;
        load_rom(16'hFF00, 16'h1101, 16'hFFFF, 16'hFFFF);
        core_lat = 1;
        start_seq();
        wait_seq(100);
        n_chk++; if (st_log.size() !== 1) $display("FAIL dly0_starts: got %0d want 1", st_log.size()); else n_pass++;
        n_chk++; if (st_cyc[0] !== g_cyc + 6) $display("FAIL dly0_lat: got %0d want %0d", st_cyc[0], g_cyc + 6); else n_pass++;
    endtask

    task automatic test_retry_ok();
        load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        core_lat = 4; nack_sub = 8'h12; nack_n = 2;
        start_seq();
        wait_seq(400);
        n_chk++; if (st_log.size() !== 4) $display("FAIL rok_starts: got %0d want 4", st_log.size()); else n_pass++;
        n_chk++; if (st_log[2] !== 16'h1280) $display("FAIL rok_w2: got %h want 1280", st_log[2]); else n_pass++;
        n_chk++; if (st_log[3] !== 16'h1101) $display("FAIL rok_w3: got %h want 1101", st_log[3]); else n_pass++;
        n_chk++; if (st_cyc[1] !== dn_cyc[0] + 1) $display("FAIL rok_retry_lat: got %0d want %0d", st_cyc[1], dn_cyc[0] + 1); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL rok_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_retry_fail();
        int n13 = 0;
        load_rom(16'h1280, 16'h1101, 16'h1302, 16'hFFFF);
        core_lat = 3; nack_sub = 8'h11; nack_n = 100;
        start_seq();
        wait_seq(400);
        foreach (st_log[i]) if (st_log[i][15:8] == 8'h13) n13++;
        n_chk++; if (st_log.size() !== 5) $display("FAIL rfail_starts: got %0d want 5", st_log.size()); else n_pass++;
        n_chk++; if (st_log[4] !== 16'h1101) $display("FAIL rfail_w4: got %h want 1101", st_log[4]); else n_pass++;
        n_chk++; if (n13 !== 0) $display("FAIL rfail_entry2: got %0d want 0", n13); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL rfail_err: got %b want 1", err); else n_pass++;
        n_chk++; if (err_idx !== 3'd1) $display("FAIL rfail_err_idx: got %0d want 1", err_idx); else n_pass++;
        n_chk++; if (sd_cnt !== 1) $display("FAIL rfail_sd_cnt: got %0d want 1", sd_cnt); else n_pass++;
        n_chk++; if (sd_cyc !== dn_cyc[4] + 1) $display("FAIL rfail_sd_lat: got %0d want %0d", sd_cyc, dn_cyc[4] + 1); else n_pass++;
        nack_n = 0;
    endtask

    task automatic test_timeout();
        // ISSUE plus 16 WAIT cycles between attempts.
        load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        core_silent = 1;
        start_seq();
        wait_seq(300);
        n_chk++; if (st_log.size() !== 4) $display("FAIL to_starts: got %0d want 4", st_log.size()); else n_pass++;
        n_chk++; if (st_cyc[1] - st_cyc[0] !== 17) $display("FAIL to_space0: got %0d want 17", st_cyc[1] - st_cyc[0]); else n_pass++;
        n_chk++; if (st_cyc[3] - st_cyc[2] !== 17) $display("FAIL to_space2: got %0d want 17", st_cyc[3] - st_cyc[2]); else n_pass++;
        n_chk++; if (sd_cyc !== st_cyc[3] + 17) $display("FAIL to_sd_lat: got %0d want %0d", sd_cyc, st_cyc[3] + 17); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL to_err: got %b want 1", err); else n_pass++;
        n_chk++; if (err_idx !== 3'd0) $display("FAIL to_err_idx: got %0d want 0", err_idx); else n_pass++;
        core_silent = 0; core_lat = 2;
        start_seq();
        n_chk++; if (err !== 1'b0) $display("FAIL to_err_clear: got %b want 0", err); else n_pass++;
        wait_seq(100);
        n_chk++; if (st_log.size() !== 1) $display("FAIL to_rerun_starts: got %0d want 1", st_log.size()); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL to_rerun_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_nowrap();
        for (int i = 0; i < 8; i++) rom[i] = {8'h20 + 8'(i), 8'h30 + 8'(i)};
        core_lat = 1;
        start_seq();
        wait_seq(300);
        n_chk++; if (st_log.size() !== 8) $display("FAIL nw_starts: got %0d want 8", st_log.size()); else n_pass++;
        n_chk++; if (st_log[7] !== 16'h2737) $display("FAIL nw_last: got %h want 2737", st_log[7]); else n_pass++;
        n_chk++; if (rom_addr !== 3'd7) $display("FAIL nw_rom_addr: got %0d want 7", rom_addr); else n_pass++;
        n_chk++; if (sd_cnt !== 1) $display("FAIL nw_sd_cnt: got %0d want 1", sd_cnt); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL nw_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_busy_reset();
        int n = 0;
        load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        core_lat = 10;
        start_seq();
        while (st_log.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        if (st_log.size() == 0) begin
            n_chk++;
            $display("FAIL br_start_wait: no sccb_start within 20 cycles");
        end
        repeat (2) tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (2) tick();
        n_chk++; if (st_log.size() !== 1) $display("FAIL br_go_ignored: got %0d want 1", st_log.size()); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL br_busy: got %b want 1", busy); else n_pass++;
        n_chk++; if (dbg_state !== 3'd4) $display("FAIL br_in_wait: got %0d want 4", dbg_state); else n_pass++;
        PRESETN = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL br_rst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (sccb_start !== 1'b0) $display("FAIL br_rst_start: got %b want 0", sccb_start); else n_pass++;
        n_chk++; if (sccb_sub_addr !== 8'h00) $display("FAIL br_rst_sub: got %h want 00", sccb_sub_addr); else n_pass++;
        n_chk++; if (sccb_wdata !== 8'h00) $display("FAIL br_rst_wdata: got %h want 00", sccb_wdata); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL br_rst_err: got %b want 0", err); else n_pass++;
        repeat (2) tick();
        PRESETN = 1'b1;
        repeat (30) tick();
        n_chk++; if (sd_cnt !== 0) $display("FAIL br_no_seq_done: got %0d want 0", sd_cnt); else n_pass++;
        n_chk++; if (st_log.size() !== 1) $display("FAIL br_no_restart: got %0d want 1", st_log.size()); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL br_idle: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
        test_reset();
        test_basic();
        test_delay();
        test_retry_ok();
        test_retry_fail();
        test_timeout();
        test_nowrap();
        test_busy_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
